fetch_stage: RTL and testbench

Instruction-fetch front end of the pipelined processor: owns the PC and issues in-order requests to instruction memory. It buffers returned words in a 2-entry queue and hands them to the IF/ID register through a valid/ready handshake. Branch/jump redirects from later stages flush the queue and discard responses still in flight. Sits directly upstream of the IF/ID register and decode.

---
 rtl/fetch_stage.sv | 154 +++++++++++++++
 tb/tb_fetch_stage.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, issues in-order fetches to
// instruction memory, buffers returned words in a small shift queue and
// presents the head to IF/ID. Redirects flush the queue and mark every
// response still in flight as stale.
module fetch_stage #(
  parameter int PC_W    = 64,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 2
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic [PC_W-1:0]    startpc,
  output logic [PC_W-1:0]    currentpc,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               ifid_valid,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [PC_W-1:0]    ifid_pc,
  input  logic               id_ready
);

  // Counters hold 0..DEPTH; FIFO pointers wrap naturally because DEPTH is a
  // power of two (fixed at 2 for this revision).
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PC_W-1:0]    pc_q;
  logic [CNT_W-1:0]   inflight_q;
  logic [CNT_W-1:0]   discard_q;
  logic [CNT_W-1:0]   count_q;

  // Address tags for in-flight requests, popped in order as responses return.
  logic [PC_W-1:0]    tag_mem [DEPTH];
  logic [PTR_W-1:0]   tag_wr_q;
  logic [PTR_W-1:0]   tag_rd_q;

  // Instruction buffer; entry 0 is always the head.
  logic [INSTR_W-1:0] buf_instr_q [DEPTH];
  logic [PC_W-1:0]    buf_pc_q    [DEPTH];
  logic [INSTR_W-1:0] buf_instr_d [DEPTH];
  logic [PC_W-1:0]    buf_pc_d    [DEPTH];

  logic               pop;
  logic               rsp;
  logic               push;
  logic               req_acc;
  logic               credit_ok;
  logic [CNT_W:0]     credit_used;
  logic [PTR_W-1:0]   wr_slot;
  logic [PC_W-1:0]    rsp_tag;

  assign currentpc  = pc_q;
  assign imem_addr  = pc_q;
  assign ifid_valid = (count_q != '0);
  assign ifid_instr = buf_instr_q[0];
  assign ifid_pc    = buf_pc_q[0];

  assign pop = ifid_valid && id_ready;

  // A response with nothing in flight is a protocol error and is ignored.
  assign rsp     = imem_rvalid && (inflight_q != '0);
  assign rsp_tag = tag_mem[tag_rd_q];
  assign push    = rsp && (discard_q == '0) && !redirect_valid;

  // Slots already claimed by buffered words or outstanding requests. A head
  // leaving this cycle frees its slot, which lets a one-cycle memory sustain
  // one fetch per cycle without ever overflowing the buffer.
  assign credit_used = {1'b0, inflight_q} + {1'b0, count_q} - (CNT_W+1)'(pop);
  assign credit_ok   = credit_used < (CNT_W+1)'(DEPTH);

  assign imem_req = !reset && !redirect_valid && credit_ok;
  assign req_acc  = imem_req && imem_gnt;

  // A simultaneous pop vacates the head first, so the new word lands one slot lower.
  assign wr_slot = PTR_W'(count_q - CNT_W'(pop));

  // Next buffer contents: shift toward the head on pop, then write the tail.
  always_comb begin
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    if (!redirect_valid) begin
      if (pop) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          buf_instr_d[i] = buf_instr_q[i+1];
          buf_pc_d[i]    = buf_pc_q[i+1];
        end
      end
      if (push) begin
        buf_instr_d[wr_slot] = imem_rdata;
        buf_pc_d[wr_slot]    = rsp_tag;
      end
    end
  end

  // Buffer storage; cleared by reset so IF/ID sees zeros out of reset.
  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_instr_q[i] <= '0;
        buf_pc_q[i]    <= '0;
      end
    end else begin
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
    end
  end

  // Tag storage: record the address of each accepted request.
  always_ff @(posedge CLK) begin
    if (req_acc) begin
      tag_mem[tag_wr_q] <= pc_q;
    end
  end

  // PC, credit counters, stale-response accounting and tag pointers.
  always_ff @(posedge CLK) begin
    if (reset) begin
      pc_q       <= startpc;
      inflight_q <= '0;
      discard_q  <= '0;
      count_q    <= '0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
    end else begin
      inflight_q <= inflight_q + CNT_W'(req_acc) - CNT_W'(rsp);
      if (req_acc) begin
        tag_wr_q <= tag_wr_q + PTR_W'(1);
      end
      if (rsp) begin
        tag_rd_q <= tag_rd_q + PTR_W'(1);
      end
      if (redirect_valid) begin
        // Everything still outstanding after this cycle belongs to the old path.
        pc_q      <= redirect_pc & ~PC_W'(3);
        discard_q <= inflight_q - CNT_W'(rsp);
        count_q   <= '0;
      end else begin
        if (req_acc) begin
          pc_q <= pc_q + PC_W'(4);
        end
        if (rsp && (discard_q != '0)) begin
          discard_q <= discard_q - CNT_W'(1);
        end
        count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: an in-order memory model with configurable latency,
// a PC model for the request address, and a scoreboard of expected IF/ID
// words filled as requests are accepted and emptied as the head is popped.
module tb_fetch_stage;
  localparam int PC_W    = 64;
  localparam int INSTR_W = 32;

  logic               CLK = 1'b0;
  logic               reset = 1'b1;
  logic [PC_W-1:0]    startpc = '0;
  logic [PC_W-1:0]    currentpc;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_gnt = 1'b0;
  logic               imem_rvalid = 1'b0;
  logic [INSTR_W-1:0] imem_rdata = '0;
  logic               redirect_valid = 1'b0;
  logic [PC_W-1:0]    redirect_pc = '0;
  logic               ifid_valid;
  logic [INSTR_W-1:0] ifid_instr;
  logic [PC_W-1:0]    ifid_pc;
  logic               id_ready = 1'b0;

  always #5 CLK = ~CLK;

  fetch_stage #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(2)) dut (
    .CLK(CLK), .reset(reset), .startpc(startpc), .currentpc(currentpc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
    .id_ready(id_ready)
  );

  typedef struct { logic [PC_W-1:0] addr; int due; } mreq_t;
  typedef struct { logic [PC_W-1:0] pc; logic [INSTR_W-1:0] instr; } exp_t;
  typedef struct {
    logic [PC_W-1:0] start;
    int              k;
    int              rcyc;
    logic [PC_W-1:0] rpc;
    logic [PC_W-1:0] a0;
    logic [PC_W-1:0] a1;
    logic [PC_W-1:0] ra;
    logic            rreq;
  } vec_t;

  mreq_t pending[$];
  exp_t  sb[$];
  int    checks = 0;
  int    passes = 0;
  int    cyc = 0;

  logic            rst_cfg = 1'b1, gnt_cfg = 1'b1, rdy_cfg = 1'b1, rv_cfg = 1'b0;
  logic [PC_W-1:0] rpc_cfg = '0, start_cfg = '0;
  int              k_cfg = 1;
  logic [PC_W-1:0] exp_pc = '0;

  logic               hold_pend = 1'b0;
  logic [PC_W-1:0]    hold_pc;
  logic [INSTR_W-1:0] hold_instr;

  logic               s_req, s_valid;
  logic [PC_W-1:0]    s_addr, s_pc, s_cur;
  logic [INSTR_W-1:0] s_instr;

  function automatic logic [INSTR_W-1:0] mem_word(input logic [PC_W-1:0] a);
    return a[31:0] ^ 32'hA5C3_0F17 ^ a[63:32];
  endfunction

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  // One clock: drive inputs on the falling edge, sample/score before the rising edge.
  task automatic tick();
    exp_t  e;
    mreq_t m;
    @(negedge CLK);
    reset = rst_cfg; startpc = start_cfg; imem_gnt = gnt_cfg; id_ready = rdy_cfg;
    redirect_valid = rv_cfg; redirect_pc = rpc_cfg;
    imem_rvalid = 1'b0; imem_rdata = '0;
    if (rst_cfg) pending.delete();
    else if (pending.size() > 0 && pending[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pending[0].addr);
      void'(pending.pop_front());
    end
    #1;
    s_req = imem_req; s_addr = imem_addr; s_valid = ifid_valid;
    s_pc = ifid_pc; s_instr = ifid_instr; s_cur = currentpc;
    if (rst_cfg) begin
      exp_pc = start_cfg; sb.delete(); hold_pend = 1'b0;
    end else begin
      check_eq("imem_addr", imem_addr, exp_pc);
      check_eq("currentpc", currentpc, exp_pc);
      if (hold_pend) begin
        check_eq("hold_valid", ifid_valid, 1);
        check_eq("hold_pc", ifid_pc, hold_pc);
        check_eq("hold_instr", ifid_instr, hold_instr);
      end
      hold_pend = ifid_valid && !id_ready && !rv_cfg;
      hold_pc = ifid_pc; hold_instr = ifid_instr;
      if (rv_cfg) begin
        check_eq("req_during_redirect", imem_req, 0);
        sb.delete();
        exp_pc = rpc_cfg & ~64'h3;
      end else begin
        if (ifid_valid && id_ready) begin
          if (sb.size() == 0) begin
            checks++;
            $display("FAIL pop_unexpected: got pc 0x%0h, expected no instruction", ifid_pc);
          end else begin
            e = sb.pop_front();
            check_eq("ifid_pc", ifid_pc, e.pc);
            check_eq("ifid_instr", ifid_instr, e.instr);
          end
        end
        if (imem_req && imem_gnt) begin
          e.pc = exp_pc; e.instr = mem_word(exp_pc); sb.push_back(e);
          m.addr = imem_addr; m.due = cyc + k_cfg; pending.push_back(m);
          exp_pc = exp_pc + 64'd4;
        end
      end
      check_eq("outstanding_le2", (pending.size() <= 2) ? 1 : 0, 1);
    end
    @(posedge CLK);
    cyc++;
  endtask

  // Two reset cycles; the second one sees the state after a reset edge.
  task automatic do_reset();
    rst_cfg = 1'b1; rv_cfg = 1'b0; gnt_cfg = 1'b1; rdy_cfg = 1'b1;
    tick();
    tick();
    check_eq("rst_currentpc", s_cur, start_cfg);
    check_eq("rst_req", s_req, 0);
    check_eq("rst_valid", s_valid, 0);
    check_eq("rst_ifid_pc", s_pc, 0);
    check_eq("rst_ifid_instr", s_instr, 0);
    rst_cfg = 1'b0;
  endtask

  // Stop granting and let every outstanding word reach IF/ID, bounded.
  task automatic drain();
    int n;
    gnt_cfg = 1'b0; rdy_cfg = 1'b1; rv_cfg = 1'b0;
    n = 0;
    while ((sb.size() != 0 || pending.size() != 0) && n < 40) begin
      tick();
      n++;
    end
    check_eq("drained", sb.size() + pending.size(), 0);
    tick();
    check_eq("empty_after_drain", s_valid, 0);
    gnt_cfg = 1'b1;
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{start: 64'h0, k: 1, rcyc: 4, rpc: 64'h47,
                a0: 64'h0, a1: 64'h4, ra: 64'h44, rreq: 1'b1};
    vecs[1] = '{start: 64'hFFFF_FFFF_FFFF_FFFC, k: 1, rcyc: 3, rpc: 64'h1000,
                a0: 64'hFFFF_FFFF_FFFF_FFFC, a1: 64'h0, ra: 64'h1000, rreq: 1'b1};
    vecs[2] = '{start: 64'h100, k: 3, rcyc: 2, rpc: 64'h40,
                a0: 64'h100, a1: 64'h104, ra: 64'h40, rreq: 1'b0};
    vecs[3] = '{start: 64'h200, k: 3, rcyc: 3, rpc: 64'h80,
                a0: 64'h200, a1: 64'h204, ra: 64'h80, rreq: 1'b1};

    // Table: start address, wrap, alignment and redirect-with-requests-in-flight.
    for (int v = 0; v < 4; v++) begin
      start_cfg = vecs[v].start; k_cfg = vecs[v].k;
      do_reset();
      for (int c = 0; c <= vecs[v].rcyc + 1; c++) begin
        rv_cfg = (c == vecs[v].rcyc); rpc_cfg = vecs[v].rpc;
        tick();
        if (c == 0) check_eq("first_addr", s_addr, vecs[v].a0);
        if (c == 1) check_eq("second_addr", s_addr, vecs[v].a1);
        if (c == vecs[v].rcyc + 1) begin
          check_eq("redirect_addr", s_addr, vecs[v].ra);
          check_eq("redirect_req", s_req, vecs[v].rreq);
          check_eq("empty_after_redirect", s_valid, 0);
        end
      end
      rv_cfg = 1'b0;
      for (int c = 0; c < 8; c++) tick();
      drain();
    end

    // Streaming at k=1, a 5-cycle stall with 0x8 at the head, then grant held low.
    start_cfg = 64'h0; k_cfg = 1;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      rdy_cfg = !(c >= 4 && c <= 8);
      gnt_cfg = !(c >= 11 && c <= 13);
      tick();
      if (c <= 3) check_eq("stream_req", s_req, 1);
      if (c <= 1) check_eq("no_early_valid", s_valid, 0);
      if (c == 2) begin
        check_eq("first_valid", s_valid, 1);
        check_eq("first_ifid_pc", s_pc, 64'h0);
      end
      if (c == 4 || c == 8) check_eq("stall_head_pc", s_pc, 64'h8);
      if (c >= 5 && c <= 8) check_eq("stall_req_stops", s_req, 0);
      if (c == 10) check_eq("after_stall_pc", s_pc, 64'hC);
      if (c >= 11 && c <= 13) check_eq("req_while_no_gnt", s_req, 1);
    end
    rdy_cfg = 1'b1; gnt_cfg = 1'b1;
    drain();

    // Redirect coinciding with a response and a pop, then a second one to 0x80.
    start_cfg = 64'h0; k_cfg = 2;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      rv_cfg = (c == 6 || c == 7);
      rpc_cfg = (c == 6) ? 64'h300 : 64'h80;
      tick();
      if (c == 6) check_eq("valid_at_redirect", s_valid, 1);
      if (c == 7) begin
        check_eq("valid_after_redirect1", s_valid, 0);
        check_eq("addr_after_redirect1", s_addr, 64'h300);
      end
      if (c == 8) begin
        check_eq("valid_after_redirect2", s_valid, 0);
        check_eq("addr_after_redirect2", s_addr, 64'h80);
        check_eq("req_after_redirect2", s_req, 1);
      end
    end
    rv_cfg = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
